oscillating_fsm_core: RTL and testbench



---
 rtl/oscillating_fsm_core_if.sv | 34 +++
 rtl/oscillating_fsm_core.sv | 88 ++++++++
 tb/tb_oscillating_fsm_core.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/oscillating_fsm_core_if.sv
// rtl/oscillating_fsm_core_if.sv - request/state bundle of the oscillating FSM core
//
// Signals:
//   A           oscillate request (driven by master, sampled by the core)
//   state       2-bit registered FSM state (driven by the core)
//   toggle_cnt  8-bit S1<->S2 toggle count, present only with OSC_FSM_TOGGLE_CNT_EN
// Modports:
//   master  request side (drives A, observes state/toggle_cnt)
//   slave   the core (observes A, drives state/toggle_cnt)
// Configuration macro: OSC_FSM_TOGGLE_CNT_EN

interface oscillating_fsm_core_if;
  logic       A;
  logic [1:0] state;
`ifdef OSC_FSM_TOGGLE_CNT_EN
  logic [7:0] toggle_cnt;
`endif

  modport master (
    output A,
    input  state
`ifdef OSC_FSM_TOGGLE_CNT_EN
    , input toggle_cnt
`endif
  );

  modport slave (
    input  A,
    output state
`ifdef OSC_FSM_TOGGLE_CNT_EN
    , output toggle_cnt
`endif
  );
endinterface

// File: rtl/oscillating_fsm_core.sv
// rtl/oscillating_fsm_core.sv - heartbeat FSM oscillating between two states while A is high
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    oscillating_fsm_core_if.slave (A in, state out, toggle_cnt out when enabled)
// Parameters:
//   DWELL  cycles spent in each oscillating state before toggling (>= 1)
// Configuration macro: OSC_FSM_TOGGLE_CNT_EN adds the 8-bit toggle counter.

module oscillating_fsm_core #(
  parameter int DWELL = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  oscillating_fsm_core_if.slave        bus
);

  localparam int DW = (DWELL <= 2) ? 1 : $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_OSC_A  = 2'b01,
    S_OSC_B  = 2'b10,
    S_RETURN = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  dwell_q, dwell_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  // Dwell defaults to zero so any state change (including entry to S1/S2)
  // clears it; it only advances while staying in an oscillating state.
  always_comb begin
    state_d = state_q;
    dwell_d = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.A) state_d = S_OSC_A;
      end
      S_OSC_A: begin
        if (!bus.A)                     state_d = S_RETURN;
        else if (dwell_q == DWELL_LAST) state_d = S_OSC_B;
        else                            dwell_d = dwell_q + DW'(1);
      end
      S_OSC_B: begin
        if (!bus.A)                     state_d = S_RETURN;
        else if (dwell_q == DWELL_LAST) state_d = S_OSC_A;
        else                            dwell_d = dwell_q + DW'(1);
      end
      S_RETURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.state = state_q;

`ifdef OSC_FSM_TOGGLE_CNT_EN
  logic [7:0] toggle_q;
  logic       toggling;

  assign toggling = ((state_q == S_OSC_A) && (state_d == S_OSC_B)) ||
                    ((state_q == S_OSC_B) && (state_d == S_OSC_A));

  // Free-running wrap; survives S3/S0 and is cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        toggle_q <= '0;
    else if (toggling) toggle_q <= toggle_q + 8'd1;
  end

  assign bus.toggle_cnt = toggle_q;
`endif

endmodule

// File: tb/tb_oscillating_fsm_core.sv
// tb/tb_oscillating_fsm_core.sv - self-checking bench for oscillating_fsm_core (DWELL=1 and DWELL=3)

module tb_oscillating_fsm_core;

  logic clk;
  logic reset;

  oscillating_fsm_core_if if1 ();
  oscillating_fsm_core_if if3 ();

  oscillating_fsm_core #(.DWELL(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  oscillating_fsm_core #(.DWELL(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 oscillating, 2 returning.
  // run = edges spent oscillating since entry; phase = run / DWELL.
  int dw   [2] = '{1, 3};
  int mode [2];
  int run  [2];
  int tog  [2];

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int exp_state(input int k);
    if (mode[k] == 0) return 0;
    if (mode[k] == 2) return 3;
    return (((run[k] / dw[k]) % 2) == 0) ? 1 : 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0;
      run[k]  = 0;
      tog[k]  = 0;
    end
  endtask

  task automatic model_edge(input int k, input logic a);
    if (!reset) begin
      mode[k] = 0;
      run[k]  = 0;
      tog[k]  = 0;
    end else begin
      case (mode[k])
        0: if (a) begin mode[k] = 1; run[k] = 0; end
        1: begin
          if (!a) mode[k] = 2;
          else begin
            run[k]++;
            if (run[k] % dw[k] == 0) tog[k] = (tog[k] + 1) % 256;
          end
        end
        default: mode[k] = 0;
      endcase
    end
  endtask

  task automatic compare_models();
    check("state_d1", int'(if1.state), exp_state(0));
    check("state_d3", int'(if3.state), exp_state(1));
`ifdef OSC_FSM_TOGGLE_CNT_EN
    check("tog_d1", int'(if1.toggle_cnt), tog[0]);
    check("tog_d3", int'(if3.toggle_cnt), tog[1]);
`endif
  endtask

  // Drive at current (negedge) time, take one rising edge, check at the next negedge.
  task automatic cycle(input logic a1, input logic a3);
    if1.A = a1;
    if3.A = a3;
    @(posedge clk);
    model_edge(0, a1);
    model_edge(1, a3);
    @(negedge clk);
    compare_models();
  endtask

  // Mid-cycle reset pulse; state must clear without any clock edge.
  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    compare_models();
    #1;
    reset = 1'b1;
  endtask

  int exp1 [5] = '{1, 2, 1, 2, 1};
  int exp3 [5] = '{1, 1, 1, 2, 2};

  initial begin
    reset = 1'b0;
    if1.A = 1'b0;
    if3.A = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_state_d1", int'(if1.state), 0);
    check("reset_state_d3", int'(if3.state), 0);

    // Reset held across edges with A=1 must keep idle.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    reset = 1'b1;

    // Oscillation and dwell sequences from idle.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1);
      check("osc_seq_d1", int'(if1.state), exp1[i]);
      check("osc_seq_d3", int'(if3.state), exp3[i]);
    end

    // Drain: d1 from S1, d3 from S2 mid-dwell; A=1 during return is ignored.
    cycle(1'b0, 1'b0);
    check("drain_ret_d1", int'(if1.state), 3);
    check("drain_ret_d3", int'(if3.state), 3);
    cycle(1'b1, 1'b1);
    check("drain_idle_d1", int'(if1.state), 0);
    check("drain_idle_d3", int'(if3.state), 0);
    cycle(1'b0, 1'b0);
    check("drain_hold_d1", int'(if1.state), 0);

    // d3 into S2 with dwell=1, then asynchronous reset, then a full 3-cycle S1 dwell.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    check("pre_reset_d3", int'(if3.state), 2);
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1);
      check("post_reset_d3", int'(if3.state), (i < 3) ? 1 : 2);
    end

    // Randomized phase with occasional reset pulses and held resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset();
        if ($urandom_range(0, 1) == 1) begin
          reset = 1'b0;
          repeat ($urandom_range(1, 3)) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          reset = 1'b1;
        end
      end else begin
        cycle(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 8));
      end
    end

    // 300 toggles at DWELL=1 from a clean reset, then drain.
    pulse_reset();
    for (int i = 0; i < 301; i++) cycle(1'b1, 1'b1);
`ifdef OSC_FSM_TOGGLE_CNT_EN
    check("tog300_d1", int'(if1.toggle_cnt), 44);
`endif
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    check("final_idle_d1", int'(if1.state), 0);
`ifdef OSC_FSM_TOGGLE_CNT_EN
    check("tog_hold_d1", int'(if1.toggle_cnt), 44);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
